// File: rtl/sb_pkg.sv
// Shared definitions for the system-bus arbiter: response codes, FSM states, width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sb_pkg;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] RESP_RETRY = 2'b10;
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWNED  = 2'd1,
    LOCKED = 2'd2,
    PARKED = 2'd3
  } arb_state_e;

  // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sb_rr_picker.sv
// Rotating-priority picker: first eligible, non-excluded master at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever inputs are.
module sb_rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  excl,
  output logic          found,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);

  logic [N-1:0] cand;
  int           j;

  // Walk the candidates starting at the pointer; the first hit wins.
  always_comb begin
    cand  = elig & ~excl;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && cand[j]) begin
        found   = 1'b1;
        pick[j] = 1'b1;
        idx     = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sb_arbiter_n.sv
// N-master round-robin bus arbiter with locked transfers, SPLIT parking and a hold limit.
// Latency: one cycle; decisions from inputs at edge t appear on registered outputs after edge t.
// Backpressure: grant only moves on hready=1 transfer boundaries (IDLE/PARKED excepted).
module sb_arbiter_n
  import sb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int MAX_HOLD  = 16,
  localparam int MW = clog2(N_MASTERS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req,
  input  logic [N_MASTERS-1:0] sb_lock,
  input  logic                 hready,
  input  logic [1:0]           resp,
  input  logic [N_MASTERS-1:0] sb_split_release,
  output logic [N_MASTERS-1:0] gnt,
  output logic [MW-1:0]        sb_masters,
  output logic                 sb_mastlock,
  output logic [N_MASTERS-1:0] split_mask
);

  localparam int PW  = clog2(N_MASTERS);
  localparam int HW0 = clog2(MAX_HOLD + 1);
  localparam int HW  = (HW0 < 1) ? 1 : HW0;

  arb_state_e           state_q, state_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [HW-1:0]        hold_q, hold_d, hold_inc;
  logic [N_MASTERS-1:0] split_mask_q, split_mask_d, split_set;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [MW-1:0]        sb_masters_q, sb_masters_d;
  logic                 sb_mastlock_q, sb_mastlock_d;

  logic [N_MASTERS-1:0] elig, excl, owner_oh, own_oh_d;
  logic                 pk_found;
  logic [N_MASTERS-1:0] pk_pick;
  logic [PW-1:0]        pk_idx;
  logic                 owned_eval, do_grant, do_drop;

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] k);
    return (k == PW'(N_MASTERS - 1)) ? '0 : k + PW'(1);
  endfunction

  assign elig     = req & ~split_mask_q;
  assign owner_oh = {{(N_MASTERS-1){1'b0}}, 1'b1} << owner_q;
  // The current owner is never a re-pick candidate while it holds the bus.
  assign excl     = (state_q == OWNED || state_q == LOCKED) ? owner_oh : '0;
  assign hold_inc = (MAX_HOLD != 0 && hold_q < HW'(MAX_HOLD)) ? hold_q + HW'(1) : hold_q;

  sb_rr_picker #(.N(N_MASTERS), .IW(PW)) u_pick (
    .elig  (elig),
    .ptr   (ptr_q),
    .excl  (excl),
    .found (pk_found),
    .pick  (pk_pick),
    .idx   (pk_idx)
  );

  // State register and all other flops; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      ptr_q         <= '0;
      hold_q        <= '0;
      split_mask_q  <= '0;
      gnt_q         <= '0;
      sb_masters_q  <= '0;
      sb_mastlock_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      hold_q        <= hold_d;
      split_mask_q  <= split_mask_d;
      gnt_q         <= gnt_d;
      sb_masters_q  <= sb_masters_d;
      sb_mastlock_q <= sb_mastlock_d;
    end
  end

  // Next-state: arbitration decision, pointer, hold counter and split parking.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    own_oh_d   = owner_oh;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    split_set  = '0;
    owned_eval = 1'b0;
    do_grant   = 1'b0;
    do_drop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pk_found) do_grant = 1'b1;
      end
      OWNED: begin
        if (hready) begin
          owned_eval = 1'b1;
          hold_d     = hold_inc;
        end
      end
      LOCKED: begin
        // Hold counter stays frozen while locked, even on the unlocking beat.
        if (hready) begin
          if (!sb_lock[owner_q]) begin
            owned_eval = 1'b1;
          end else if (resp == RESP_SPLIT) begin
            split_set = owner_oh;
            state_d   = PARKED;
          end
        end
      end
      PARKED: begin
        // Only the parked lock owner may resume; everyone else waits.
        if (sb_split_release[owner_q]) begin
          state_d = LOCKED;
          hold_d  = '0;
          ptr_d   = ptr_after(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase

    if (owned_eval) begin
      state_d = OWNED;
      if (resp == RESP_SPLIT) begin
        split_set = owner_oh;
        if (pk_found) do_grant = 1'b1;
        else          do_drop  = 1'b1;
      end else if (sb_lock[owner_q] && req[owner_q]) begin
        state_d = LOCKED;
      end else if (!req[owner_q]) begin
        if (pk_found) do_grant = 1'b1;
        else          do_drop  = 1'b1;
      end else if (MAX_HOLD != 0 && hold_d == HW'(MAX_HOLD) && pk_found) begin
        do_grant = 1'b1;
      end
    end

    if (do_grant) begin
      state_d  = OWNED;
      owner_d  = pk_idx;
      own_oh_d = pk_pick;
      ptr_d    = ptr_after(pk_idx);
      hold_d   = '0;
    end else if (do_drop) begin
      state_d = IDLE;
      hold_d  = '0;
    end

    // A SPLIT landing in the same beat as its release keeps the bit set.
    split_mask_d = (split_mask_q & ~sb_split_release) | split_set;
  end

  // Output decode: grant lines and mux select follow the next state, so they stay consistent.
  always_comb begin
    gnt_d         = '0;
    sb_masters_d  = '0;
    sb_mastlock_d = (state_d == LOCKED) || (state_d == PARKED);
    if (state_d == OWNED || state_d == LOCKED) begin
      gnt_d        = own_oh_d;
      sb_masters_d = MW'(owner_d) + MW'(1);
    end
  end

  assign gnt         = gnt_q;
  assign sb_masters  = sb_masters_q;
  assign sb_mastlock = sb_mastlock_q;
  assign split_mask  = split_mask_q;

endmodule

// File: tb/tb_sb_arbiter_n.sv
// Bench for sb_arbiter_n: three instances (N=2 unlimited hold, N=2 hold 4, N=4) on shared stimulus.
// Latency: expectations are queued with each driven beat and checked 1 time unit after the edge.
// Backpressure: n/a.
module tb_sb_arbiter_n;

  localparam int D_H0 = 0;  // N=2, MAX_HOLD=0
  localparam int D_H4 = 1;  // N=2, MAX_HOLD=4
  localparam int D_N4 = 2;  // N=4, MAX_HOLD=16

  logic       clk;
  logic       rst;
  logic [3:0] req, lock, rel;
  logic       hready;
  logic [1:0] resp;

  logic [1:0] gnt_h0, ms_h0, sm_h0;
  logic       ml_h0;
  logic [1:0] gnt_h4, ms_h4, sm_h4;
  logic       ml_h4;
  logic [3:0] gnt_n4, sm_n4;
  logic [2:0] ms_n4;
  logic       ml_n4;

  typedef struct {
    int         dut;
    logic [3:0] gnt;
    logic [2:0] ms;
    logic       ml;
    logic [3:0] sm;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk;
  int   n_err;

  sb_arbiter_n #(.N_MASTERS(2), .MAX_HOLD(0)) u_h0 (
    .clk(clk), .rst(rst), .req(req[1:0]), .sb_lock(lock[1:0]), .hready(hready), .resp(resp),
    .sb_split_release(rel[1:0]), .gnt(gnt_h0), .sb_masters(ms_h0), .sb_mastlock(ml_h0),
    .split_mask(sm_h0)
  );

  sb_arbiter_n #(.N_MASTERS(2), .MAX_HOLD(4)) u_h4 (
    .clk(clk), .rst(rst), .req(req[1:0]), .sb_lock(lock[1:0]), .hready(hready), .resp(resp),
    .sb_split_release(rel[1:0]), .gnt(gnt_h4), .sb_masters(ms_h4), .sb_mastlock(ml_h4),
    .split_mask(sm_h4)
  );

  sb_arbiter_n #(.N_MASTERS(4), .MAX_HOLD(16)) u_n4 (
    .clk(clk), .rst(rst), .req(req), .sb_lock(lock), .hready(hready), .resp(resp),
    .sb_split_release(rel), .gnt(gnt_n4), .sb_masters(ms_n4), .sb_mastlock(ml_n4),
    .split_mask(sm_n4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                       input logic hr, input logic [1:0] rs, input logic [3:0] rl);
    rst    = r;
    req    = rq;
    lock   = lk;
    hready = hr;
    resp   = rs;
    rel    = rl;
  endtask

  task automatic expect_out(input int dut, input logic [3:0] g, input logic [2:0] m,
                            input logic l, input logic [3:0] s, input string tag);
    exp_t e;
    e.dut = dut; e.gnt = g; e.ms = m; e.ml = l; e.sm = s; e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Advance one edge, then retire every expectation queued for that edge.
  task automatic tick();
    exp_t       e;
    logic [3:0] og, os;
    logic [2:0] om;
    logic       ol;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.dut)
        D_H0:    begin og = {2'b00, gnt_h0}; om = {1'b0, ms_h0}; ol = ml_h0; os = {2'b00, sm_h0}; end
        D_H4:    begin og = {2'b00, gnt_h4}; om = {1'b0, ms_h4}; ol = ml_h4; os = {2'b00, sm_h4}; end
        default: begin og = gnt_n4;          om = ms_n4;         ol = ml_n4; os = sm_n4;          end
      endcase
      chk_eq({e.tag, ".gnt"},  32'(og), 32'(e.gnt));
      chk_eq({e.tag, ".mast"}, 32'(om), 32'(e.ms));
      chk_eq({e.tag, ".lock"}, 32'(ol), 32'(e.ml));
      chk_eq({e.tag, ".smsk"}, 32'(os), 32'(e.sm));
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 4'hF, 4'h0, 1'b0, 2'b00, 4'h0);
    expect_out(D_H0, 4'h0, 3'd0, 1'b0, 4'h0, "rst_h0");
    expect_out(D_N4, 4'h0, 3'd0, 1'b0, 4'h0, "rst_n4");
    tick();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    drive(1'b1, 4'hF, 4'h0, 1'b0, 2'b00, 4'h0);

    // Reset held two cycles with everyone requesting, then first grant goes to master 0.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'hF, 4'h0, 1'b0, 2'b00, 4'h0);
      expect_out(D_H0, 4'h0, 3'd0, 1'b0, 4'h0, "t1_rst_h0");
      expect_out(D_H4, 4'h0, 3'd0, 1'b0, 4'h0, "t1_rst_h4");
      expect_out(D_N4, 4'h0, 3'd0, 1'b0, 4'h0, "t1_rst_n4");
      tick();
    end
    drive(1'b0, 4'h3, 4'h0, 1'b0, 2'b00, 4'h0);
    expect_out(D_H0, 4'h1, 3'd1, 1'b0, 4'h0, "t1_first_h0");
    expect_out(D_H4, 4'h1, 3'd1, 1'b0, 4'h0, "t1_first_h4");
    tick();

    // Round robin on four masters: owner drops req for one boundary, then re-requests.
    do_reset();
    drive(1'b0, 4'hF, 4'h0, 1'b1, 2'b00, 4'h0);
    expect_out(D_N4, 4'h1, 3'd1, 1'b0, 4'h0, "t2_g0");
    tick();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 4'hF & ~(4'h1 << ((k - 1) % 4)), 4'h0, 1'b1, 2'b00, 4'h0);
      expect_out(D_N4, 4'h1 << (k % 4), 3'((k % 4) + 1), 1'b0, 4'h0, "t2_rot");
      tick();
      drive(1'b0, 4'hF, 4'h0, 1'b1, 2'b00, 4'h0);
      expect_out(D_N4, 4'h1 << (k % 4), 3'((k % 4) + 1), 1'b0, 4'h0, "t2_keep");
      tick();
    end

    // Lock: master 1 keeps the bus while master 0 requests; unlock hands over.
    do_reset();
    drive(1'b0, 4'h2, 4'h0, 1'b0, 2'b00, 4'h0);
    expect_out(D_H0, 4'h2, 3'd2, 1'b0, 4'h0, "t3_own1");
    tick();
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 4'h3, 4'h2, 1'b1, 2'b00, 4'h0);
      expect_out(D_H0, 4'h2, 3'd2, 1'b1, 4'h0, "t3_locked");
      tick();
    end
    drive(1'b0, 4'h1, 4'h0, 1'b1, 2'b00, 4'h0);
    expect_out(D_H0, 4'h1, 3'd1, 1'b0, 4'h0, "t3_unlock");
    tick();

    // Split: master 0 parked, master 1 takes over, release, set-beats-release.
    do_reset();
    drive(1'b0, 4'h3, 4'h0, 1'b0, 2'b00, 4'h0);
    expect_out(D_H0, 4'h1, 3'd1, 1'b0, 4'h0, "t4_own0");
    tick();
    drive(1'b0, 4'h3, 4'h0, 1'b1, 2'b11, 4'h0);
    expect_out(D_H0, 4'h2, 3'd2, 1'b0, 4'h1, "t4_split");
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'h3, 4'h0, 1'b1, 2'b00, 4'h0);
      expect_out(D_H0, 4'h2, 3'd2, 1'b0, 4'h1, "t4_masked");
      tick();
    end
    drive(1'b0, 4'h3, 4'h0, 1'b0, 2'b00, 4'h1);
    expect_out(D_H0, 4'h2, 3'd2, 1'b0, 4'h0, "t4_release");
    tick();
    drive(1'b0, 4'h3, 4'h0, 1'b0, 2'b00, 4'h2);
    expect_out(D_H0, 4'h2, 3'd2, 1'b0, 4'h0, "t4_rel_unmasked");
    tick();
    drive(1'b0, 4'h1, 4'h0, 1'b1, 2'b00, 4'h0);
    expect_out(D_H0, 4'h1, 3'd1, 1'b0, 4'h0, "t4_back0");
    tick();
    drive(1'b0, 4'h3, 4'h0, 1'b1, 2'b11, 4'h1);
    expect_out(D_H0, 4'h2, 3'd2, 1'b0, 4'h1, "t4_set_wins");
    tick();

    // Fairness: hold limit 4 alternates owners every 4 beats; unlimited never moves.
    // RETRY and ERROR beats count as completed transfers like OKAY.
    do_reset();
    drive(1'b0, 4'h3, 4'h0, 1'b1, 2'b00, 4'h0);
    expect_out(D_H0, 4'h1, 3'd1, 1'b0, 4'h0, "t5_g0_h0");
    expect_out(D_H4, 4'h1, 3'd1, 1'b0, 4'h0, "t5_g0_h4");
    tick();
    for (int k = 1; k <= 50; k++) begin
      drive(1'b0, 4'h3, 4'h0, 1'b1, 2'(k % 3), 4'h0);
      expect_out(D_H0, 4'h1, 3'd1, 1'b0, 4'h0, "t5_nolimit");
      expect_out(D_H4, 4'h1 << ((k / 4) % 2), 3'(((k / 4) % 2) + 1), 1'b0, 4'h0, "t5_limit4");
      tick();
    end

    // Split while locked parks the bus; release resumes the lock; reset clears everything.
    do_reset();
    drive(1'b0, 4'h1, 4'h1, 1'b0, 2'b00, 4'h0);
    expect_out(D_H0, 4'h1, 3'd1, 1'b0, 4'h0, "t6_own0");
    tick();
    drive(1'b0, 4'h1, 4'h1, 1'b1, 2'b00, 4'h0);
    expect_out(D_H0, 4'h1, 3'd1, 1'b1, 4'h0, "t6_lock");
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 4'h3, 4'h1, 1'b1, 2'b00, 4'h0);
      expect_out(D_H0, 4'h1, 3'd1, 1'b1, 4'h0, "t6_lock_hold");
      tick();
    end
    drive(1'b0, 4'h3, 4'h1, 1'b1, 2'b11, 4'h0);
    expect_out(D_H0, 4'h0, 3'd0, 1'b1, 4'h1, "t6_parked");
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'h3, 4'h1, 1'b1, 2'b00, 4'h0);
      expect_out(D_H0, 4'h0, 3'd0, 1'b1, 4'h1, "t6_park_hold");
      tick();
    end
    drive(1'b0, 4'h3, 4'h1, 1'b0, 2'b00, 4'h1);
    expect_out(D_H0, 4'h1, 3'd1, 1'b1, 4'h0, "t6_resume");
    tick();
    drive(1'b0, 4'h3, 4'h1, 1'b1, 2'b00, 4'h0);
    expect_out(D_H0, 4'h1, 3'd1, 1'b1, 4'h0, "t6_relocked");
    tick();
    drive(1'b1, 4'h3, 4'h1, 1'b1, 2'b00, 4'h0);
    expect_out(D_H0, 4'h0, 3'd0, 1'b0, 4'h0, "t6_rst_locked");
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
